edge_mem_responder: RTL
=======================

EDGE_MEM_RESPONDER -- requirements
Module: edge_mem_responder

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 64, edge/read-data word width.
REQ-002 SHALL have parameter WLINE_W, default 512, kernel write-line width (8 x 64-bit words).
REQ-003 SHALL have parameter EDGE_AW, default 10, edge RAM address width (1024 words).
REQ-004 SHALL have parameter UPD_AW, default 10, update RAM address width (1024 x 64-bit words).
REQ-005 SHALL have parameter RD_LAT, default 2, fixed read latency in cycles (legal 1..4).
REQ-006 SHALL have parameter WB_DEPTH, default 4, write-line buffer depth.
REQ-007 SHALL use one clock; reset asynchronous, active-high: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-008 SHALL have: go  in  1  host pulse starting a run; edge_count  in  32  number of valid edges, sampled on go.
REQ-009 SHALL have: ld_we  in  1; ld_addr  in  EDGE_AW; ld_data  in  64 -- host edge preload port.
REQ-010 SHALL have: RAddr0  in  32  kernel read word address; RAddrV0  in  1  read request valid.
REQ-011 SHALL have: RData0  out  64  read data; RDataV0  out  1  read data valid.
REQ-012 SHALL have: WData0  in  512  kernel write line; WDataV0  in  1  write line valid.
REQ-013 SHALL have: r_en0  out  1  read accept; w_en0  out  1  write accept; start  out  1  kernel run enable.
REQ-014 SHALL have: hr_addr  in  UPD_AW; hr_data  out  64 -- host update readback, 1-cycle latency.
REQ-015 SHALL have: done  out  1  one-cycle completion pulse; err  out  1  sticky out-of-range flag.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on go; RUN -> DRAIN when accepted read count == edge_count; DRAIN -> DONE when read pipe and write buffer empty and drain engine idle; DONE -> IDLE after one cycle.
REQ-017 SHALL hold start=1 and r_en0=1 only in RUN; start=0, r_en0=0 in all other states.
REQ-018 SHALL accept a read when RAddrV0 & r_en0; RData0/RDataV0 SHALL appear exactly RD_LAT cycles later, one response per accepted request, in order, no backpressure.
REQ-019 SHALL return edge RAM word RAddr0[EDGE_AW-1:0] when RAddr0 < edge_count; otherwise RData0=0 with RDataV0=1 and err set until reset.
REQ-020 SHALL hold RData0 at 0 when RDataV0=0.
REQ-021 SHALL assert w_en0 in RUN and DRAIN while buffer occupancy < WB_DEPTH; accept a line when WDataV0 & w_en0.
REQ-022 SHALL drain lines from the buffer at one 64-bit word per cycle, word 0 = WData0[63:0] first, 8 cycles per line, into update RAM at wr_ptr, wr_ptr incrementing and wrapping from 2^UPD_AW-1 to 0.
REQ-023 SHALL allow push and pop of the buffer in the same cycle; occupancy unchanged.
REQ-024 SHALL reset wr_ptr to 0 on go; go outside IDLE SHALL be ignored.
REQ-025 SHALL with edge_count=0 pass RUN -> DRAIN on the next cycle, accepting no reads.
REQ-026 SHALL write ld_data when ld_we in any state; ld_we and a read to the same address in the same cycle returns old data.
REQ-027 SHALL pulse done for exactly one cycle in DONE.

Reset
REQ-028 SHALL on rst, at any time including mid-run, force state IDLE, RData0=0, RDataV0=0, r_en0=0, w_en0=0, start=0, done=0, err=0, wr_ptr=0, read pipe and buffer empty; RAM contents undefined-preserved.

Structure
REQ-029 SHALL place widths, RD_LAT/WB_DEPTH defaults and FSM state encoding in shared package graph_mem_pkg.
REQ-030 SHALL instantiate one sub-module wline_fifo (synchronous WLINE_W x WB_DEPTH FIFO with count).
REQ-031 SHALL realise the read pipe as an RD_LAT-deep valid/data shift register; target 120-400 RTL lines.

Verification
REQ-032 Preload 0:64'h0000000100000000, 1:64'h0000000200000001, 5:64'h0000000200000005; go, edge_count=6; request 0,1,5 back-to-back -> RData0 same words in order, each 2 cycles after request.
REQ-033 edge_count=6, request RAddr0=6 -> RDataV0=1, RData0=0, err=1 and stays 1 until rst.
REQ-034 Push 5 lines back-to-back in RUN -> w_en0 falls after 4th accept; after drain, hr_addr 0..39 reads words in line/word order.
REQ-035 Set wr_ptr near 1023 via 130 lines -> words past 1023 land at 0 onward.
REQ-036 6 accepted reads with 2 lines buffered -> done pulses once only after last drain word; start falls when 6th read accepted.
REQ-037 Assert rst mid-run with reads in flight and buffer non-empty -> all outputs 0 next edge, no further RDataV0, state IDLE.

Source files
------------

// File: rtl/graph_mem_pkg.sv
// Shared widths, depths and FSM encoding for the graph edge/update memory responder.
package graph_mem_pkg;

  localparam int FIFO_WIDTH_DEF = 64;
  localparam int WLINE_W_DEF    = 512;
  localparam int EDGE_AW_DEF    = 10;
  localparam int UPD_AW_DEF     = 10;
  localparam int RD_LAT_DEF     = 2;
  localparam int WB_DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/wline_fifo.sv
// Show-ahead synchronous FIFO holding kernel write lines, with occupancy count.
module wline_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    push_ok = push && (cnt_q != CW'(DEPTH));
    pop_ok  = pop && (cnt_q != '0);
    wp_d    = push_ok ? inc(wp_q) : wp_q;
    rp_d    = pop_ok ? inc(rp_q) : rp_q;
    cnt_d   = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp_q] <= din;
  end

  assign dout  = mem[rp_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/edge_mem_responder.sv
// Serves kernel edge reads from a preloaded RAM and drains kernel
// write lines word-by-word into an update RAM readable by the host.
module edge_mem_responder
  import graph_mem_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int WLINE_W    = WLINE_W_DEF,
  parameter int EDGE_AW    = EDGE_AW_DEF,
  parameter int UPD_AW     = UPD_AW_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int WB_DEPTH   = WB_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [31:0]           edge_count,
  input  logic                  ld_we,
  input  logic [EDGE_AW-1:0]    ld_addr,
  input  logic [FIFO_WIDTH-1:0] ld_data,
  input  logic [31:0]           RAddr0,
  input  logic                  RAddrV0,
  output logic [FIFO_WIDTH-1:0] RData0,
  output logic                  RDataV0,
  input  logic [WLINE_W-1:0]    WData0,
  input  logic                  WDataV0,
  output logic                  r_en0,
  output logic                  w_en0,
  output logic                  start,
  input  logic [UPD_AW-1:0]     hr_addr,
  output logic [FIFO_WIDTH-1:0] hr_data,
  output logic                  done,
  output logic                  err
);

  localparam int WPL = WLINE_W / FIFO_WIDTH;
  localparam int IW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int CW  = $clog2(WB_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] edge_ram [2**EDGE_AW];
  logic [FIFO_WIDTH-1:0] upd_ram  [2**UPD_AW];

  state_e                state_q, state_d;
  logic [31:0]           ecnt_q, ecnt_d;
  logic [31:0]           rdcnt_q, rdcnt_d;
  logic [UPD_AW-1:0]     wp_q, wp_d;
  logic [IW-1:0]         widx_q, widx_d;
  logic                  err_q, err_d;
  logic [RD_LAT-1:0]     pv_q, pv_d;
  logic [FIFO_WIDTH-1:0] pd_q [RD_LAT];
  logic [FIFO_WIDTH-1:0] pd_d [RD_LAT];
  logic [FIFO_WIDTH-1:0] hr_q, hr_d;

  logic                  rd_acc;
  logic                  in_rng;
  logic                  go_ok;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [WLINE_W-1:0]    fifo_dout;
  logic [CW-1:0]         fifo_cnt;
  logic [FIFO_WIDTH-1:0] drain_word;

  wline_fifo #(
    .W     (WLINE_W),
    .DEPTH (WB_DEPTH),
    .CW    (CW)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (WData0),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // The head line stays in the FIFO while drained, so count is true occupancy.
  always_comb begin
    rd_acc    = RAddrV0 & r_en0;
    in_rng    = RAddr0 < ecnt_q;
    go_ok     = go && (state_q == ST_IDLE);
    fifo_push = WDataV0 & w_en0;
    fifo_pop  = !fifo_empty && (widx_q == IW'(WPL - 1));
    drain_word = '0;
    for (int i = 0; i < WPL; i++) begin
      if (widx_q == IW'(i)) drain_word = fifo_dout[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (go) state_d = ST_RUN;
      ST_RUN:   if (rdcnt_d == ecnt_q) state_d = ST_DRAIN;
      ST_DRAIN: if (pv_q == '0 && fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ecnt_d  = ecnt_q;
    rdcnt_d = rdcnt_q + (rd_acc ? 32'd1 : 32'd0);
    wp_d    = fifo_empty ? wp_q : wp_q + UPD_AW'(1);
    widx_d  = widx_q;
    if (!fifo_empty) widx_d = fifo_pop ? '0 : widx_q + IW'(1);
    if (go_ok) begin
      ecnt_d  = edge_count;
      rdcnt_d = '0;
      wp_d    = '0;
    end
    err_d = err_q | (rd_acc & ~in_rng);
    hr_d  = upd_ram[hr_addr];
    pv_d[0] = rd_acc;
    pd_d[0] = (rd_acc && in_rng) ? edge_ram[RAddr0[EDGE_AW-1:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_comb begin
    start   = (state_q == ST_RUN);
    r_en0   = (state_q == ST_RUN) && (rdcnt_q != ecnt_q);
    w_en0   = ((state_q == ST_RUN) || (state_q == ST_DRAIN))
              && (fifo_cnt < CW'(WB_DEPTH));
    done    = (state_q == ST_DONE);
    err     = err_q;
    RDataV0 = pv_q[RD_LAT-1];
    RData0  = pd_q[RD_LAT-1];
    hr_data = hr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ecnt_q  <= '0;
      rdcnt_q <= '0;
      wp_q    <= '0;
      widx_q  <= '0;
      err_q   <= 1'b0;
      hr_q    <= '0;
      pv_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      rdcnt_q <= rdcnt_d;
      wp_q    <= wp_d;
      widx_q  <= widx_d;
      err_q   <= err_d;
      hr_q    <= hr_d;
      pv_q    <= pv_d;
      for (int i = 0; i < RD_LAT; i++) pd_q[i] <= pd_d[i];
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_we) edge_ram[ld_addr] <= ld_data;
    if (!fifo_empty) upd_ram[wp_q] <= drain_word;
  end

endmodule
